// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared register-file write definitions for the writeback arbiter:
// bus widths, write-enable encodings, the zero word and reset polarity,
// plus the FSM state and round-robin pointer encodings.
package regfile_wr_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic                  WRITEABLE     = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_ADDR     = '0;
    localparam logic                  RST_ENABLE    = 1'b1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } ptr_e;

    // x0 is hard-wired zero: a request aimed at it is accepted but dropped
    function automatic logic addr_writable(input logic [REG_ADDR_W-1:0] a);
        return a != ZERO_ADDR;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter.sv
// Two-port (ALU / LSU) register-file writeback arbiter.
// One write per cycle reaches the registered regfile port; contention is
// resolved by a 1-bit round-robin pointer that only moves on contention.
// Optional macro REGFILE_CLEAR_EN: after reset, sweep zero into
// x[CLR_FIRST]..x[NUM_REGS-1] (one per cycle) before granting anything.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int CLR_FIRST = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_addr,
    input  logic [REG_DATA_W-1:0] alu_data,
    output logic                  alu_ready,
    input  logic                  lsu_valid,
    input  logic [REG_ADDR_W-1:0] lsu_addr,
    input  logic [REG_DATA_W-1:0] lsu_data,
    output logic                  lsu_ready,
    output logic                  write_or_not,
    output logic [REG_ADDR_W-1:0] writeaddr,
    output logic [REG_DATA_W-1:0] writedata,
    output logic                  busy
);

    // Reject configurations the 5-bit address / clear counter cannot express
    if (NUM_REGS < 2 || NUM_REGS > (1 << REG_ADDR_W) ||
        CLR_FIRST < 1 || CLR_FIRST >= NUM_REGS) begin : g_bad_cfg
        $error("regfile_wr_arbiter: unsupported NUM_REGS / CLR_FIRST");
    end

    logic                  w_run;
    logic                  w_busy;
    logic                  w_out_en;
    logic                  w_clr_we;
    logic [REG_ADDR_W-1:0] w_clr_addr;

    ptr_e                  r_ptr;
    ptr_e                  w_ptr_nxt;
    logic                  w_gnt_alu;
    logic                  w_gnt_lsu;

    logic                  w_we;
    logic [REG_ADDR_W-1:0] w_wa;
    logic [REG_DATA_W-1:0] w_wd;
    logic                  r_we;
    logic [REG_ADDR_W-1:0] r_wa;
    logic [REG_DATA_W-1:0] r_wd;

`ifdef REGFILE_CLEAR_EN
    localparam logic [REG_ADDR_W-1:0] CLR_FIRST_A = REG_ADDR_W'(CLR_FIRST);
    localparam logic [REG_ADDR_W-1:0] CLR_LAST_A  = REG_ADDR_W'(NUM_REGS - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [REG_ADDR_W-1:0] r_clr_cnt;
    logic                  w_clr_last;

    assign w_clr_last = (r_clr_cnt == CLR_LAST_A);

    // State register: reset always restarts the clear sweep
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RST_ENABLE) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: leave CLEAR once the last register has been written
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    // Clear counter: one register index per CLEAR cycle, holds at the end
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RST_ENABLE) begin
            r_clr_cnt <= CLR_FIRST_A;
        end else if (r_state == ST_CLEAR && !w_clr_last) begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
        end
    end

    // FSM outputs: grants only in RUN, sweep writes only in CLEAR
    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_busy     = (r_state == ST_CLEAR);
        w_clr_we   = (r_state == ST_CLEAR);
        w_clr_addr = r_clr_cnt;
    end

    // The state flop already drops to CLEAR asynchronously under reset
    assign w_out_en = 1'b1;
`else
    // No sweep: the arbiter is live as soon as reset is released
    assign w_run      = 1'b1;
    assign w_busy     = 1'b0;
    assign w_clr_we   = 1'b0;
    assign w_clr_addr = ZERO_ADDR;
    // Ready must still read 0 while reset is held
    assign w_out_en   = ~rst_in;
`endif

    // Inline 2-way round-robin pick; the pointer names the tie winner
    always_comb begin
        w_gnt_alu = w_run && alu_valid && (!lsu_valid || r_ptr == PTR_ALU);
        w_gnt_lsu = w_run && lsu_valid && (!alu_valid || r_ptr == PTR_LSU);
        w_ptr_nxt = r_ptr;
        if (w_run && alu_valid && lsu_valid) begin
            w_ptr_nxt = (r_ptr == PTR_ALU) ? PTR_LSU : PTR_ALU;
        end
    end

    // Round-robin pointer: starts with the ALU favoured
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RST_ENABLE) begin
            r_ptr <= PTR_ALU;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Write source select; idle cycles present an all-zero port
    always_comb begin
        w_we = WRITE_DISABLE;
        w_wa = ZERO_ADDR;
        w_wd = ZERO_WORD;
        if (w_clr_we) begin
            w_we = WRITEABLE;
            w_wa = w_clr_addr;
        end else if (w_gnt_alu && addr_writable(alu_addr)) begin
            w_we = WRITEABLE;
            w_wa = alu_addr;
            w_wd = alu_data;
        end else if (w_gnt_lsu && addr_writable(lsu_addr)) begin
            w_we = WRITEABLE;
            w_wa = lsu_addr;
            w_wd = lsu_data;
        end
    end

    // Registered regfile write port; reset kills any in-flight write
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in == RST_ENABLE) begin
            r_we <= WRITE_DISABLE;
            r_wa <= ZERO_ADDR;
            r_wd <= ZERO_WORD;
        end else begin
            r_we <= w_we;
            r_wa <= w_wa;
            r_wd <= w_wd;
        end
    end

    assign alu_ready    = w_gnt_alu & w_out_en;
    assign lsu_ready    = w_gnt_lsu & w_out_en;
    assign write_or_not = r_we;
    assign writeaddr    = r_wa;
    assign writedata    = r_wd;
    assign busy         = w_busy;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus randomized traffic
// checked against a rule-level model (tie-winner flag, expected write,
// shadow register files). Honours REGFILE_CLEAR_EN when defined.
`timescale 1ns/1ps
module tb_regfile_wr_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_ready;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic        lsu_ready;
    logic        write_or_not;
    logic [4:0]  writeaddr;
    logic [31:0] writedata;
    logic        busy;

    regfile_wr_arbiter #(.NUM_REGS(32), .CLR_FIRST(1)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .alu_valid    (alu_valid),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .alu_ready    (alu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_addr     (lsu_addr),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .write_or_not (write_or_not),
        .writeaddr    (writeaddr),
        .writedata    (writedata),
        .busy         (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_tie_lsu;     // LSU wins the next tie when set
    bit          e_we;          // write expected on the port next cycle
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] m_rf [32];     // contents implied by the rules
    logic [31:0] o_rf [32];     // contents implied by observed writes
    bit          watch9 = 1'b0;
    bit          bad9   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One RUN cycle: check grants and write port, then advance the model
    task automatic step(output bit oa, output bit ol);
        bit ga, gl;
        @(negedge clk_in);
        if (alu_valid && lsu_valid) begin
            ga = !m_tie_lsu;
            gl = m_tie_lsu;
            m_tie_lsu = !m_tie_lsu;
        end else begin
            ga = alu_valid;
            gl = lsu_valid;
        end
        check_eq("alu_ready", alu_ready, ga);
        check_eq("lsu_ready", lsu_ready, gl);
        check_eq("wr_en",   write_or_not, e_we);
        check_eq("wr_addr", writeaddr, e_wa);
        check_eq("wr_data", writedata, e_wd);
        if (write_or_not) o_rf[writeaddr] = writedata;
        e_we = 1'b0; e_wa = '0; e_wd = '0;
        if (ga && alu_addr != 5'd0) begin
            e_we = 1'b1; e_wa = alu_addr; e_wd = alu_data; m_rf[alu_addr] = alu_data;
        end
        if (gl && lsu_addr != 5'd0) begin
            e_we = 1'b1; e_wa = lsu_addr; e_wd = lsu_data; m_rf[lsu_addr] = lsu_data;
        end
        oa = alu_ready;
        ol = lsu_ready;
        @(posedge clk_in);
        #1;
    endtask

    // Random requester: a stalled request is held unchanged until granted
    task automatic new_reqs(input bit oa, input bit ol);
        if (!alu_valid || oa) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_addr  = 5'($urandom_range(0, 15));
            alu_data  = $urandom;
        end
        if (!lsu_valid || ol) begin
            lsu_valid = ($urandom_range(0, 3) != 0);
            lsu_addr  = 5'($urandom_range(0, 15));
            lsu_data  = $urandom;
        end
    endtask

    // Assert reset (if not already), check reset state, release, run any sweep
    task automatic reset_and_sweep();
        rst_in    = 1'b1;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h0000_0033;
        lsu_valid = 1'b0; lsu_addr = 5'd0; lsu_data = 32'h0;
        #1;
        check_eq("rst_we",      write_or_not, 0);
        check_eq("rst_wa",      writeaddr, 0);
        check_eq("rst_wd",      writedata, 0);
        check_eq("rst_alu_rdy", alu_ready, 0);
        check_eq("rst_lsu_rdy", lsu_ready, 0);
        repeat (2) @(posedge clk_in);
        #1 rst_in = 1'b0;
        m_tie_lsu = 1'b0;
        e_we = 1'b0; e_wa = '0; e_wd = '0;
`ifdef REGFILE_CLEAR_EN
        for (int i = 1; i < 32; i++) begin
            @(negedge clk_in);
            check_eq("clr_busy",    busy, 1);
            check_eq("clr_alu_rdy", alu_ready, 0);
            @(posedge clk_in);
            #1;
            check_eq("clr_we",   write_or_not, 1);
            check_eq("clr_addr", writeaddr, 32'(i));
            check_eq("clr_data", writedata, 0);
            m_rf[i] = 32'h0;
            if (write_or_not) o_rf[writeaddr] = writedata;
        end
        check_eq("clr_done_busy", busy, 0);
        check_eq("clr_done_rdy",  alu_ready, 1);
        e_we = 1'b1; e_wa = 5'd31; e_wd = 32'h0;
`else
        check_eq("run_busy", busy, 0);
`endif
    endtask

    // Flags any write of the request that was aborted by reset
    always @(negedge clk_in) begin
        if (watch9 && write_or_not && writeaddr == 5'd9 && writedata == 32'h0000_0099)
            bad9 <= 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit oa, ol;
        for (int r = 0; r < 32; r++) begin
            m_rf[r] = 32'h0;
            o_rf[r] = 32'h0;
        end

        reset_and_sweep();
        step(oa, ol);                       // drains the x3 request held through reset

        // ALU alone, x5 <= DEADBEEF
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
        lsu_valid = 1'b0;
        step(oa, ol);
        check_eq("t_alu_rdy", oa, 1);
        alu_valid = 1'b0;
        check_eq("t_alu_we", write_or_not, 1);
        check_eq("t_alu_wa", writeaddr, 5);
        check_eq("t_alu_wd", writedata, 32'hDEAD_BEEF);
        step(oa, ol);

        // Sustained contention with the ALU favoured: ALU, LSU, ALU, LSU
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA000_0000;
        lsu_valid = 1'b1; lsu_addr = 5'd11; lsu_data = 32'hB000_0000;
        for (int k = 0; k < 4; k++) begin
            step(oa, ol);
            check_eq("t_rr_alu", oa, (k % 2 == 0));
            check_eq("t_rr_lsu", ol, (k % 2 == 1));
            check_eq("t_rr_wa",  writeaddr, (k % 2 == 0) ? 10 : 11);
            if (oa) alu_data = 32'hA000_0000 + 32'(k + 1);
            if (ol) lsu_data = 32'hB000_0000 + 32'(k + 1);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step(oa, ol);

        // Same-address contention on x7: loser's value lands last
        alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h1;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'h2;
        step(oa, ol);
        check_eq("t_x7_first_alu", oa, 1);
        check_eq("t_x7_first_lsu", ol, 0);
        alu_valid = 1'b0;
        check_eq("t_x7_w1_addr", writeaddr, 7);
        check_eq("t_x7_w1_data", writedata, 1);
        step(oa, ol);
        check_eq("t_x7_second_lsu", ol, 1);
        lsu_valid = 1'b0;
        check_eq("t_x7_w2_we",   write_or_not, 1);
        check_eq("t_x7_w2_addr", writeaddr, 7);
        check_eq("t_x7_w2_data", writedata, 2);
        step(oa, ol);
        check_eq("t_x7_final", o_rf[7], 2);

        // Write to x0 is accepted and dropped
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'hFFFF_FFFF;
        step(oa, ol);
        check_eq("t_x0_rdy", ol, 1);
        lsu_valid = 1'b0;
        check_eq("t_x0_we", write_or_not, 0);
        check_eq("t_x0_wd", writedata, 0);
        step(oa, ol);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            step(oa, ol);
            new_reqs(oa, ol);
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (2) step(oa, ol);
        for (int r = 1; r < 32; r++) check_eq("rf_final", o_rf[r], m_rf[r]);

        // Reset pulsed while a request is being accepted
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h0000_0044;
        lsu_valid = 1'b0;
        step(oa, ol);
        alu_addr = 5'd9; alu_data = 32'h0000_0099;
        watch9 = 1'b1;
        @(negedge clk_in);
        check_eq("t_rst_pre_rdy", alu_ready, 1);
        check_eq("t_rst_pre_we",  write_or_not, 1);
        rst_in = 1'b1;
        #1;
        check_eq("t_rst_async_we",  write_or_not, 0);
        check_eq("t_rst_async_wa",  writeaddr, 0);
        check_eq("t_rst_async_wd",  writedata, 0);
        check_eq("t_rst_async_rdy", alu_ready, 0);
        reset_and_sweep();
        alu_valid = 1'b0;
        repeat (3) step(oa, ol);
        check_eq("t_rst_no_x9", bad9, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
